// File: rtl/fb_cmd_if.sv
// Byte-stream input and framebuffer write-port bundle for fb_cmd_ctrl.
// master = decoder/test side, slave = the command controller.
interface fb_cmd_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              frame_end;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              err;

  modport master (
    output in_valid, in_data, frame_end,
    input  in_ready, wr_en, wr_addr, wr_data, busy, err
  );

  modport slave (
    input  in_valid, in_data, frame_end,
    output in_ready, wr_en, wr_addr, wr_data, busy, err
  );
endinterface

// File: rtl/fb_cmd_ctrl.sv
// Framebuffer command sequencer: parses decoded COBS bytes into
// set-address / data / fill / clear commands and is the sole owner of the
// framebuffer write port. All outputs are registered; a byte accepted on
// edge N shows up as a write in the cycle right after that edge.
module fb_cmd_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  fb_cmd_if.slave  bus
);

  typedef enum logic [3:0] {
    S_MODE, S_DATA, S_ADDR_LO, S_ADDR_HI, S_FILL_COL, S_FILL_CLO,
    S_FILL_CHI, S_FILL_RUN, S_CLR_COL, S_CLR_RUN, S_DISCARD
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   waddr, waddr_n;
  logic [ADDR_W-1:0]   cnt, cnt_n;      // writes still owed after the current one
  logic [DATA_W-1:0]   col, col_n;
  logic [DATA_W-1:0]   lo, lo_n;        // low byte held until the high byte arrives
  logic                we_q, we_n;
  logic [ADDR_W-1:0]   wa_q, wa_n;
  logic [DATA_W-1:0]   wd_q, wd_n;
  logic                err_q, err_n;
  logic                busy_q, busy_n;
  logic                rdy_q, rdy_n;
  logic                acc;
  logic [2*DATA_W-1:0] pair;
  logic [ADDR_W-1:0]   pair_w;
  logic                run_st;

  assign acc    = bus.in_valid && rdy_q;
  assign pair   = {bus.in_data, lo};
  assign pair_w = ADDR_W'(pair);
  assign run_st = (state == S_FILL_RUN) || (state == S_CLR_RUN);

  // Next-state and next-output decode; frame_end resyncs every non-run state.
  always_comb begin
    state_n = state;
    waddr_n = waddr;
    cnt_n   = cnt;
    col_n   = col;
    lo_n    = lo;
    we_n    = 1'b0;
    wa_n    = wa_q;
    wd_n    = wd_q;
    err_n   = 1'b0;
    if (!run_st && bus.frame_end) begin
      state_n = S_MODE;
    end else begin
      case (state)
        S_MODE: if (acc) begin
          case (bus.in_data)
            DATA_W'(1): state_n = S_DATA;
            DATA_W'(2): state_n = S_ADDR_LO;
            DATA_W'(3): state_n = S_FILL_COL;
            DATA_W'(4): state_n = S_CLR_COL;
            default: begin
              state_n = S_DISCARD;
              err_n   = 1'b1;
            end
          endcase
        end
        S_DATA: if (acc) begin
          we_n    = 1'b1;
          wa_n    = waddr;
          wd_n    = bus.in_data;
          waddr_n = waddr + ADDR_W'(1);
        end
        S_ADDR_LO: if (acc) begin
          lo_n    = bus.in_data;
          state_n = S_ADDR_HI;
        end
        S_ADDR_HI: if (acc) begin
          waddr_n = pair_w;
          state_n = S_MODE;
        end
        S_FILL_COL: if (acc) begin
          col_n   = bus.in_data;
          state_n = S_FILL_CLO;
        end
        S_FILL_CLO: if (acc) begin
          lo_n    = bus.in_data;
          state_n = S_FILL_CHI;
        end
        // First fill write is issued on the same edge that takes count_hi.
        S_FILL_CHI: if (acc) begin
          if (pair_w == '0) begin
            state_n = S_MODE;
          end else begin
            we_n    = 1'b1;
            wa_n    = waddr;
            wd_n    = col;
            waddr_n = waddr + ADDR_W'(1);
            cnt_n   = pair_w - ADDR_W'(1);
            state_n = S_FILL_RUN;
          end
        end
        S_FILL_RUN: begin
          if (cnt == '0) begin
            state_n = S_MODE;
          end else begin
            we_n    = 1'b1;
            wa_n    = waddr;
            wd_n    = col;
            waddr_n = waddr + ADDR_W'(1);
            cnt_n   = cnt - ADDR_W'(1);
          end
        end
        // Clear writes address 0 on the colour edge, then walks up until wrap.
        S_CLR_COL: if (acc) begin
          col_n   = bus.in_data;
          we_n    = 1'b1;
          wa_n    = '0;
          wd_n    = bus.in_data;
          waddr_n = ADDR_W'(1);
          state_n = S_CLR_RUN;
        end
        S_CLR_RUN: begin
          if (waddr == '0) begin
            state_n = S_MODE;
          end else begin
            we_n    = 1'b1;
            wa_n    = waddr;
            wd_n    = col;
            waddr_n = waddr + ADDR_W'(1);
          end
        end
        S_DISCARD: ;
        default: state_n = S_MODE;
      endcase
    end
    busy_n = (state_n == S_FILL_RUN) || (state_n == S_CLR_RUN);
    rdy_n  = !busy_n;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_MODE;
    else      state <= state_n;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr  <= '0;
      cnt    <= '0;
      col    <= '0;
      lo     <= '0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      waddr  <= waddr_n;
      cnt    <= cnt_n;
      col    <= col_n;
      lo     <= lo_n;
      we_q   <= we_n;
      wa_q   <= wa_n;
      wd_q   <= wd_n;
      err_q  <= err_n;
      busy_q <= busy_n;
      rdy_q  <= rdy_n;
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.wr_en    = we_q;
  assign bus.wr_addr  = wa_q;
  assign bus.wr_data  = wd_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_fb_cmd_ctrl.sv
// Directed bench for fb_cmd_ctrl.
module tb_fb_cmd_ctrl;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  fb_cmd_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  fb_cmd_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running tallies sampled mid-cycle; sections compare deltas.
  int          mon_wcnt   = 0;
  int          mon_busy   = 0;
  int          mon_nrdy   = 0;
  int          mon_nonseq = 0;
  int          mon_c1c    = 0;
  logic [15:0] mon_last   = 16'h0;
  always @(negedge clk) begin
    if (bus.wr_en) begin
      mon_wcnt <= mon_wcnt + 1;
      if (bus.wr_addr != mon_last + 16'd1) mon_nonseq <= mon_nonseq + 1;
      if (bus.wr_data == 8'h1C) mon_c1c <= mon_c1c + 1;
      mon_last <= bus.wr_addr;
    end
    if (bus.busy) mon_busy <= mon_busy + 1;
    if (!bus.in_ready && rst) mon_nrdy <= mon_nrdy + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a byte, hold until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 70000) check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic pulse_fe();
    @(negedge clk);
    bus.frame_end = 1'b1;
    @(posedge clk);
    #1 bus.frame_end = 1'b0;
  endtask

  task automatic chkw(input string tag, input logic [15:0] a, input logic [7:0] d);
    check({tag, "_en"},   32'(bus.wr_en),   32'd1);
    check({tag, "_addr"}, 32'(bus.wr_addr), 32'(a));
    check({tag, "_data"}, 32'(bus.wr_data), 32'(d));
  endtask

  int bw, bb, bn, bs, bc, n;

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",   32'(bus.wr_en),    32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr),  32'd0);
    check("rst_wr_data", 32'(bus.wr_data),  32'd0);
    check("rst_busy",    32'(bus.busy),     32'd0);
    check("rst_err",     32'(bus.err),      32'd0);
    check("rst_ready",   32'(bus.in_ready), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 check("ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 32'(bus.in_ready), 32'd1);

    // Set address then stream three bytes.
    bw = mon_wcnt;
    send(8'h02); send(8'h34); send(8'h12); send(8'h01);
    send(8'hAA); chkw("t1_w0", 16'h1234, 8'hAA);
    send(8'hBB); chkw("t1_w1", 16'h1235, 8'hBB);
    send(8'hCC); chkw("t1_w2", 16'h1236, 8'hCC);
    @(posedge clk);
    #1 check("t1_idle_en", 32'(bus.wr_en), 32'd0);
    check("t1_wcount", 32'(mon_wcnt - bw), 32'd3);

    // Address wrap.
    pulse_fe();
    send(8'h02); send(8'hFE); send(8'hFF); send(8'h01);
    send(8'h11); chkw("t2_w0", 16'hFFFE, 8'h11);
    send(8'h22); chkw("t2_w1", 16'hFFFF, 8'h22);
    send(8'h33); chkw("t2_w2", 16'h0000, 8'h33);

    // Fill of 5 at 0x1000.
    pulse_fe();
    send(8'h02); send(8'h00); send(8'h10);
    send(8'h03); send(8'hE0); send(8'h05);
    bw = mon_wcnt; bb = mon_busy; bn = mon_nrdy;
    send(8'h00); chkw("t3_first", 16'h1000, 8'hE0);
    check("t3_busy_on", 32'(bus.busy), 32'd1);
    check("t3_ready_off", 32'(bus.in_ready), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("t3_wcount",  32'(mon_wcnt - bw), 32'd5);
    check("t3_busycnt", 32'(mon_busy - bb), 32'd5);
    check("t3_nrdycnt", 32'(mon_nrdy - bn), 32'd5);
    check("t3_last_addr", 32'(mon_last), 32'h1004);
    send(8'h01);
    send(8'h7F); chkw("t3_after", 16'h1005, 8'h7F);

    // Zero-count fill is a no-op.
    pulse_fe();
    bw = mon_wcnt; bb = mon_busy;
    send(8'h03); send(8'h55); send(8'h00); send(8'h00);
    check("t4_en", 32'(bus.wr_en), 32'd0);
    check("t4_ready", 32'(bus.in_ready), 32'd1);
    send(8'h01);
    check("t4_wcount",  32'(mon_wcnt - bw), 32'd0);
    check("t4_busycnt", 32'(mon_busy - bb), 32'd0);
    send(8'h66); chkw("t4_next", 16'h1006, 8'h66);

    // Clear screen; frame_end mid-run ignored.
    pulse_fe();
    bw = mon_wcnt; bb = mon_busy; bs = mon_nonseq; bc = mon_c1c;
    send(8'h04);
    send(8'h1C); chkw("t5_first", 16'h0000, 8'h1C);
    repeat (100) @(posedge clk);
    pulse_fe();
    n = 0;
    while (bus.busy && n < 70000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 70000) check("t5_run_timeout", 32'(bus.busy), 32'd0);
    check("t5_wcount",  32'(mon_wcnt - bw), 32'd65536);
    check("t5_busycnt", 32'(mon_busy - bb), 32'd65536);
    check("t5_color",   32'(mon_c1c - bc),  32'd65536);
    // Only the jump from 0x1006 down to 0x0000 breaks the address sequence.
    check("t5_nonseq",  32'(mon_nonseq - bs), 32'd1);
    check("t5_last_addr", 32'(mon_last), 32'hFFFF);
    send(8'h01);
    send(8'h01); chkw("t5_after", 16'h0000, 8'h01);

    // Unknown opcode then discard.
    pulse_fe();
    bw = mon_wcnt;
    send(8'h09);
    check("t6_err_on", 32'(bus.err), 32'd1);
    @(posedge clk);
    #1 check("t6_err_off", 32'(bus.err), 32'd0);
    send(8'h01); send(8'hAA);
    check("t6_discard_wcount", 32'(mon_wcnt - bw), 32'd0);
    pulse_fe();
    send(8'h01);
    send(8'hAA); chkw("t6_resync", 16'h0001, 8'hAA);

    // Reset in the middle of a long fill.
    pulse_fe();
    send(8'h03); send(8'h77); send(8'h00);
    send(8'h10); chkw("t7_first", 16'h0002, 8'h77);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t7_rst_en",    32'(bus.wr_en),    32'd0);
    check("t7_rst_busy",  32'(bus.busy),     32'd0);
    check("t7_rst_ready", 32'(bus.in_ready), 32'd0);
    check("t7_rst_addr",  32'(bus.wr_addr),  32'd0);
    bw = mon_wcnt;
    repeat (5) @(posedge clk);
    #1;
    check("t7_no_writes", 32'(mon_wcnt - bw), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t7_idle_after", 32'(bus.wr_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_cmd_ctrl.md
Name: fb_cmd_ctrl

Overview:
- Command sequencer between the COBS byte decoder and the 256x256 byte framebuffer RAM write port.
- Parses the decoded byte stream into commands: set address, stream data, fill run, clear screen.
- Issues at most one RAM write per clock and back-pressures the decoder while a fill or clear is running.
- Replaces ad-hoc write logic in the video generator with a single owner of the framebuffer write port.

Parameters:
- ADDR_W, 16, framebuffer address width (2^ADDR_W bytes).
- DATA_W, 8, pixel byte width (RGB332).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded byte available.
- in_data  in  DATA_W  decoded byte.
- in_ready  out  1  controller accepts byte; transfer occurs when in_valid && in_ready.
- frame_end  in  1  one-cycle pulse at COBS packet delimiter (0x00).
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- busy  out  1  fill/clear engine running.
- err  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Reset (rst=0, async) values: wr_en=0, wr_addr=0, wr_data=0, busy=0, err=0, in_ready=0. Internal state: state=MODE, waddr=0. in_ready rises one clk after rst deasserts.
- States: MODE, DATA, ADDR_LO, ADDR_HI, FILL_COL, FILL_CLO, FILL_CHI, FILL_RUN, CLR_COL, CLR_RUN, DISCARD.
- in_ready: 1 in every state except FILL_RUN and CLR_RUN.
- MODE: the accepted byte is an opcode.
  - 0x01 -> DATA.
  - 0x02 -> ADDR_LO.
  - 0x03 -> FILL_COL.
  - 0x04 -> CLR_COL.
  - Any other value -> DISCARD, with err pulsed the next cycle.
- DATA: each accepted byte b at cycle N produces wr_en=1, wr_addr=waddr, wr_data=b at cycle N+1. waddr increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000). Stays in DATA until frame_end.
- ADDR_LO: byte goes to waddr[7:0], then ADDR_HI.
- ADDR_HI: byte goes to waddr[15:8], then MODE. waddr is fully replaced only after both bytes.
- FILL_COL: latch colour. FILL_CLO: latch count[7:0]. FILL_CHI: latch count[15:8], then FILL_RUN.
  - count=0: no writes, go straight to MODE.
- FILL_RUN: writes begin the cycle after count_hi is accepted. One write per cycle: wr_addr=waddr, wr_data=colour, waddr++ with wrap. Exactly count writes, then MODE. waddr ends at start+count mod 2^ADDR_W.
- CLR_COL: latch colour, then CLR_RUN.
- CLR_RUN: writes all 2^ADDR_W addresses, 0 upward, one per cycle, then MODE. waddr=0 on exit.
- busy=1 exactly in the cycles where FILL_RUN/CLR_RUN writes are issued.
- DISCARD: accepts and drops bytes until frame_end.
- frame_end:
  - In any non-RUN state, forces MODE next cycle.
  - Takes priority over a byte accepted in the same cycle; that byte is consumed and dropped, no write.
  - In FILL_RUN/CLR_RUN it is ignored; the run completes and returns to MODE.
  - waddr is never changed by frame_end.
- wr_en is low in every cycle without a write. wr_addr/wr_data hold their last values when wr_en=0.
- Reset asserted mid-run aborts immediately: no further writes, all outputs at reset values.

Test Plan:
- Reset, send 02 34 12, 01 AA BB CC -> writes (0x1234,AA),(0x1235,BB),(0x1236,CC), each 1 cycle after acceptance; no other wr_en.
- Send 02 FE FF, 01 11 22 33 -> writes at 0xFFFE, 0xFFFF, 0x0000 (wrap).
- Send 02 00 10, 03 E0 05 00 -> in_ready=0 and busy=1 for exactly 5 cycles; writes E0 at 0x1000..0x1004; a following 01 7F writes 7F at 0x1005.
- Send 03 55 00 00 (count 0) -> no writes, busy never high, next opcode accepted normally.
- Send 04 1C -> 65536 consecutive writes of 1C covering 0x0000..0xFFFF; frame_end pulsed mid-run has no effect; a following 01 01 writes at 0x0000.
- Send 09 -> err pulses one cycle, bytes 01 AA ignored until frame_end, then 01 AA writes; separately, assert rst mid-fill -> wr_en drops at once and stays 0.
